seq_comparator_ge: RTL and testbench
====================================

SEQ_COMPARATOR_GE -- requirements
Module: seq_comparator_ge

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits compared per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-008 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-009 SHALL have port out_valid  output  1  result held.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port ge  output  1  result: 1 iff a >= b (unsigned); the complement of unsigned a < b.
REQ-012 SHALL have port eq  output  1  1 iff a == b (only present under CMP_EQ_OUT_EN).

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready, latch a, b, set digit index to WIDTH/DIGIT-1 (MSB digit), go SCAN.
REQ-016 SHALL, each SCAN cycle, compare the indexed digit of latched A and B, MSB-first.
REQ-017 SHALL, on an unequal digit, register ge=(A digit > B digit), eq=0, go DONE (early termination).
REQ-018 SHALL, on an equal digit at index 0, register ge=1, eq=1, go DONE; otherwise decrement the index and stay in SCAN.
REQ-019 SHALL hold ge/eq stable in DONE until out_valid&&out_ready, then go IDLE.
REQ-020 SHALL give latency: out_valid asserted k+1 cycles after the accepting edge, where k = number of digits scanned (1..WIDTH/DIGIT); worst case 9 cycles at defaults.
REQ-021 SHALL not accept new operands in the DONE-exit cycle (no bypass); next accept is earliest one cycle after the handshake.
REQ-022 SHALL ignore a, b and in_valid changes outside IDLE.
REQ-023 SHALL treat operands as unsigned; no sign handling; all-ones vs zero yields ge=1.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE with in_ready=1, out_valid=0, ge=0, eq=0, index=0, latched operands=0.
REQ-025 SHALL abort any SCAN/DONE transaction on rst mid-operation; the pending result is discarded and never presented.
REQ-026 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-027 SHALL compile the eq port and its register when macro SEQ_CMP_EQ_OUT_EN is defined.
REQ-028 SHALL, without SEQ_CMP_EQ_OUT_EN, omit the eq port entirely; ge behaviour and timing are identical in both builds.

Structure
REQ-029 SHALL place the state enum type (IDLE/SCAN/DONE), default WIDTH/DIGIT constants and the digit-count constant in shared package seq_cmp_pkg.
REQ-030 SHALL instantiate one combinational sub-module cmp_digit (DIGIT-bit inputs; outputs gt, eq) for the per-cycle digit compare.

Verification
REQ-031 SHALL cover a=0x80000000, b=0x7FFFFFFF -> ge=1, eq=0, out_valid 2 cycles after accept.
REQ-032 SHALL cover a=0x12345678, b=0x12345679 -> ge=0, eq=0, out_valid 9 cycles after accept.
REQ-033 SHALL cover a=b=0xDEADBEEF -> ge=1, eq=1, out_valid 9 cycles after accept.
REQ-034 SHALL cover out_ready held 0 for 5 cycles in DONE with a=0, b=1 -> ge=0 stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-035 SHALL cover rst=1 during SCAN of a=0xFFFFFFFF, b=0 -> next cycle in_ready=1, out_valid=0, ge=0; no result is emitted.
REQ-036 SHALL cover 10k random operand pairs with random out_ready stalls -> ge matches reference model !(a<b), with the eq check run in the SEQ_CMP_EQ_OUT_EN build.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types and defaults for the digit-serial unsigned comparator.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } cmp_state_e;

    localparam int unsigned DefaultWidth     = 32;
    localparam int unsigned DefaultDigit     = 4;
    localparam int unsigned DefaultNumDigits = DefaultWidth / DefaultDigit;

    function automatic int unsigned num_digits(int unsigned width, int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational compare of one DIGIT-bit slice of each operand.
module cmp_digit
    import seq_cmp_pkg::*;
#(
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_comparator_ge.sv
// Digit-serial unsigned a >= b comparator, MSB digit first with early exit.
// Define SEQ_CMP_EQ_OUT_EN to add the registered eq output.
module seq_comparator_ge
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DIGIT = DefaultDigit
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SEQ_CMP_EQ_OUT_EN
    output logic             eq,
`endif
    output logic             ge
);

    localparam int unsigned NumDigits = num_digits(WIDTH, DIGIT);
    localparam int unsigned IdxW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [IdxW-1:0] MsbIdx = IdxW'(NumDigits - 1);

    if (WIDTH % DIGIT != 0) begin : gen_bad_cfg
        $error("seq_comparator_ge: WIDTH must be a multiple of DIGIT");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             ge_q, ge_d;
`ifdef SEQ_CMP_EQ_OUT_EN
    logic             eq_q, eq_d;
`endif

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_gt, dig_eq;

    always_comb begin
        a_sh  = a_q >> (idx_q * DIGIT);
        b_sh  = b_q >> (idx_q * DIGIT);
        a_dig = a_sh[DIGIT-1:0];
        b_dig = b_sh[DIGIT-1:0];
    end

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .a  (a_dig),
        .b  (b_dig),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        ge_d      = ge_q;
`ifdef SEQ_CMP_EQ_OUT_EN
        eq_d      = eq_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = MsbIdx;
                    state_d = StScan;
                end
            end
            StScan: begin
                // First unequal digit from the top decides the result.
                if (!dig_eq) begin
                    ge_d    = dig_gt;
`ifdef SEQ_CMP_EQ_OUT_EN
                    eq_d    = 1'b0;
`endif
                    state_d = StDone;
                end else if (idx_q == '0) begin
                    ge_d    = 1'b1;
`ifdef SEQ_CMP_EQ_OUT_EN
                    eq_d    = 1'b1;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            ge_q    <= 1'b0;
`ifdef SEQ_CMP_EQ_OUT_EN
            eq_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            ge_q    <= ge_d;
`ifdef SEQ_CMP_EQ_OUT_EN
            eq_q    <= eq_d;
`endif
        end
    end

    assign ge = ge_q;
`ifdef SEQ_CMP_EQ_OUT_EN
    assign eq = eq_q;
`endif

endmodule

// File: tb/tb_seq_comparator_ge.sv
// Directed and randomised bench for seq_comparator_ge at default WIDTH/DIGIT.
module tb_seq_comparator_ge;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        ge;
`ifdef SEQ_CMP_EQ_OUT_EN
    logic        eq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_comparator_ge dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SEQ_CMP_EQ_OUT_EN
        .eq        (eq),
`endif
        .ge        (ge)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Number of digits the comparator must scan before it can decide.
    function automatic int digits_scanned(logic [31:0] x, logic [31:0] y);
        for (int i = 7; i >= 0; i--) begin
            if (x[i*4 +: 4] != y[i*4 +: 4]) return 8 - i;
        end
        return 8;
    endfunction

    // Offer one pair, wait for the result, hold it for 'stall' cycles, then take it.
    // Latency is counted in cycles from the handshake cycle (index 0).
    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic exp_ge, input logic exp_eq, input int exp_lat,
                       input int stall, input bit full);
        int cyc;
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        out_ready = (stall == 0);
        if (full) check({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        step();
        cyc = 1;
        // Garbage on the inputs outside IDLE must not disturb the result.
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
        end
        check({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, ".ge"}, 32'(ge), 32'(exp_ge));
`ifdef SEQ_CMP_EQ_OUT_EN
        check({tag, ".eq"}, 32'(eq), 32'(exp_eq));
`else
        if (exp_eq !== exp_eq) $display("unreachable");
`endif
        for (int i = 0; i < stall; i++) begin
            step();
            if (full) begin
                check({tag, ".stall_ge"}, 32'(ge), 32'(exp_ge));
                check({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
                check({tag, ".stall_out_valid"}, 32'(out_valid), 32'd1);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".back_idle"}, 32'(in_ready), 32'd1);
        if (full) check({tag, ".out_valid_low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, mask;
        int          st;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.ge", 32'(ge), 32'd0);
`ifdef SEQ_CMP_EQ_OUT_EN
        check("reset.eq", 32'(eq), 32'd0);
`endif
        rst = 1'b0;

        run("msb_gt", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2, 0, 1'b1);
        run("lsb_lt", 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 9, 0, 1'b1);
        run("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 9, 0, 1'b1);

        // Abort mid-scan; ge is 1 from the previous result so the clear is visible.
        in_valid  = 1'b1;
        a         = 32'hFFFF_FFFF;
        b         = 32'h0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.ge", 32'(ge), 32'd0);
`ifdef SEQ_CMP_EQ_OUT_EN
        check("abort.eq", 32'(eq), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort.no_result", 32'(out_valid), 32'd0);
        end

        // Reset wins over a simultaneous accept.
        in_valid = 1'b1;
        a        = 32'h1;
        b        = 32'h0;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio.in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        check("rst_prio.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        run("stall", 32'h0, 32'h1, 1'b0, 1'b0, 9, 5, 1'b1);
        run("max_vs_zero", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 2, 0, 1'b1);
        run("mid_digit", 32'hABC0_0000, 32'hAB9F_FFFF, 1'b1, 1'b0, 4, 2, 1'b1);

        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            st = $urandom_range(0, 15);
            if (st < 4) begin
                mask = 32'hFFFF_FFFF << (4 * $urandom_range(1, 7));
                rb   = (ra & mask) | (rb & ~mask);
            end else if (st == 4) begin
                rb = ra;
            end
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run("rand", ra, rb, !(ra < rb), (ra == rb), digits_scanned(ra, rb) + 1, st, 1'b0);
        end

        in_valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
